// File: rtl/riscv_fetch_pkg.sv
// rtl/riscv_fetch_pkg.sv - shared types and constants for the instruction fetch stage
// Purpose: fetch FSM state encoding, queue entry layout, instruction width and PC step.
package riscv_fetch_pkg;

  localparam int          ILEN   = 32;
  localparam logic [31:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    DROP
  } fetch_state_e;

  typedef struct packed {
    logic [ILEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - first-word-fall-through queue of fetched {pc, instr} entries
// Purpose: buffers fetched instructions for decode; head is read combinationally.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   i_clear        synchronous flush (wins over push/pop)
//   i_push/i_data  write one entry at the tail
//   i_pop          remove the head (ignored when empty)
//   o_head/o_valid head entry (zero when empty) and non-empty flag
//   o_count        number of stored entries, 0..DEPTH
module fetch_fifo
  import riscv_fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clear,
  input  logic         i_push,
  input  fetch_entry_t i_data,
  input  logic         i_pop,
  output fetch_entry_t o_head,
  output logic         o_valid,
  output logic [CW-1:0] o_count
);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_pop;

  assign o_valid  = (r_count != '0);
  assign w_do_pop = i_pop & o_valid;
  assign o_head   = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_count  = r_count;

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push)   r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(i_push) - CW'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_clear) r_mem[r_wr_ptr] <= i_data;
  end

  // The fetch FSM only requests when a slot is free, so a push into a full queue is a design bug.
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst)
    !(i_push && !i_clear && !w_do_pop && r_count == CW'(DEPTH)));

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch stage with single-outstanding imem requests
// Purpose: owns the fetch PC, requests instructions one at a time and queues the
// returned {pc, instr} pairs for decode; a redirect flushes everything in flight.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   redirect_i/redirect_pc_i  load a new fetch PC (low two bits dropped) and flush
//   imem_req_o/imem_addr_o    request and its address (always the fetch PC)
//   imem_gnt_i                request accepted this cycle
//   imem_rvalid_i/imem_rdata_i response strobe and instruction word
//   dec_valid_o/dec_pc_o/dec_instr_o/dec_ready_i  queue head handshake towards decode
module instr_fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        dec_valid_o,
  output logic [31:0] dec_pc_o,
  output logic [31:0] dec_instr_o,
  input  logic        dec_ready_i
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e    r_state;
  logic [ILEN-1:0] r_fetch_pc;
  logic [ILEN-1:0] r_resp_pc;

  fetch_entry_t    w_head;
  fetch_entry_t    w_push_entry;
  logic            w_head_valid;
  logic            w_push;
  logic            w_pop;
  logic [CW-1:0]   w_count;
  logic [CW:0]     w_count_next;
  logic            w_space_next;
  logic [31:0]     w_redirect_pc;

  assign imem_req_o  = (r_state == REQ);
  assign imem_addr_o = r_fetch_pc;

  // Decode never sees a head in a redirect cycle, so nothing is popped while flushing.
  assign dec_valid_o = w_head_valid & ~redirect_i;
  assign dec_pc_o    = w_head.pc;
  assign dec_instr_o = w_head.instr;

  assign w_pop         = dec_valid_o & dec_ready_i;
  assign w_push        = (r_state == RESP) & imem_rvalid_i & ~redirect_i;
  assign w_push_entry  = '{pc: r_resp_pc, instr: imem_rdata_i};
  assign w_redirect_pc = redirect_pc_i & ~32'h3;

  // Occupancy after this cycle's push/pop; the extra bit keeps count+1 from wrapping.
  assign w_count_next = {1'b0, w_count} + (CW+1)'(w_push) - (CW+1)'(w_pop);
  assign w_space_next = (w_count_next < (CW+1)'(DEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= '0;
    end else if (redirect_i) begin
      r_fetch_pc <= w_redirect_pc;
      // A granted-but-unreturned request must be drained in DROP before refetching.
      case (r_state)
        REQ:        r_state <= imem_gnt_i ? DROP : REQ;
        RESP, DROP: r_state <= imem_rvalid_i ? REQ : DROP;
        default:    r_state <= REQ;
      endcase
    end else begin
      case (r_state)
        IDLE: if (w_space_next) r_state <= REQ;
        REQ: begin
          if (imem_gnt_i) begin
            r_resp_pc  <= r_fetch_pc;
            r_fetch_pc <= r_fetch_pc + PC_INC;
            r_state    <= RESP;
          end
        end
        RESP: if (imem_rvalid_i) r_state <= w_space_next ? REQ : IDLE;
        DROP: if (imem_rvalid_i) r_state <= REQ;
        default: r_state <= IDLE;
      endcase
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clear (redirect_i),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_valid (w_head_valid),
    .o_count (w_count)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        dec_valid_o;
  logic [31:0] dec_pc_o;
  logic [31:0] dec_instr_o;
  logic        dec_ready_i;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .dec_valid_o   (dec_valid_o),
    .dec_pc_o      (dec_pc_o),
    .dec_instr_o   (dec_instr_o),
    .dec_ready_i   (dec_ready_i)
  );

  int checks = 0;
  int errors = 0;
  int gnt_pct = 100;
  int rv_pct  = 100;

  // Reference model: expected decode queue, expected next fetch address, outstanding response.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc = RESET_PC;
  logic [31:0] m_out_addr = '0;
  bit          m_outst = 0;
  bit          m_stale = 0;
  int          m_pops = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_F00D;
  endfunction

  // Instruction memory: grants with probability gnt_pct, answers the outstanding request with rv_pct.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      imem_gnt_i    = 1'b0;
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
    end else begin
      #1;
      imem_gnt_i    = imem_req_o && (int'($urandom_range(99)) < gnt_pct);
      imem_rvalid_i = m_outst && (int'($urandom_range(99)) < rv_pct);
      imem_rdata_i  = imem_rvalid_i ? mem_word(m_out_addr) : 32'h0;
    end
  end

  // Advance the model to reflect the coming clock edge.
  task automatic model_step();
    if (!rst) begin
      mq.delete();
      m_pc = RESET_PC; m_outst = 0; m_stale = 0;
      return;
    end
    if (mq.size() != 0 && !redirect_i && dec_ready_i) begin
      void'(mq.pop_front());
      m_pops++;
    end
    if (imem_rvalid_i) begin
      if (!m_stale && !redirect_i) mq.push_back('{m_out_addr, mem_word(m_out_addr)});
      m_outst = 0; m_stale = 0;
    end
    if (imem_req_o && imem_gnt_i) begin
      m_outst = 1; m_stale = 0; m_out_addr = m_pc; m_pc = m_pc + 32'd4;
    end
    if (redirect_i) begin
      mq.delete();
      m_pc    = {redirect_pc_i[31:2], 2'b00};
      m_stale = m_outst;
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    redirect_i = 0; redirect_pc_i = '0; dec_ready_i = 0; rst = 0;
    @(negedge clk);
    cyc();
    rst = 1;
  endtask

  task automatic test_reset();
    gnt_pct = 0; rv_pct = 100;
    rst = 0; redirect_i = 0; redirect_pc_i = '0; dec_ready_i = 0;
    @(negedge clk);
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", imem_req_o); end
    checks++; if (dec_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", dec_valid_o); end
    checks++; if (dec_pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", dec_pc_o); end
    checks++; if (dec_instr_o !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", dec_instr_o); end
    checks++; if (imem_addr_o !== RESET_PC) begin errors++; $display("FAIL reset_addr got %h exp %h", imem_addr_o, RESET_PC); end
    cyc();
    rst = 1;
    @(negedge clk);
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL release_idle_req got %b exp 0", imem_req_o); end
    cyc();
    @(negedge clk);
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== RESET_PC) begin
      errors++; $display("FAIL first_req got req=%b addr=%h exp req=1 addr=%h", imem_req_o, imem_addr_o, RESET_PC);
    end
    cyc();
  endtask

  task automatic test_zero_wait();
    logic [31:0] exp_pc;
    gnt_pct = 100; rv_pct = 100;
    apply_reset();
    dec_ready_i = 1;
    exp_pc = RESET_PC;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++; if (dec_valid_o !== (i >= 3 && i % 2 == 1)) begin
        errors++; $display("FAIL zw_cadence cycle %0d got valid=%b exp %b", i, dec_valid_o, (i >= 3 && i % 2 == 1));
      end
      if (dec_valid_o) begin
        checks++; if (dec_pc_o !== exp_pc || dec_instr_o !== mem_word(exp_pc)) begin
          errors++; $display("FAIL zw_entry got pc=%h instr=%h exp pc=%h instr=%h", dec_pc_o, dec_instr_o, exp_pc, mem_word(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
      end
      cyc();
    end
  endtask

  task automatic test_full();
    logic [31:0] exp_pc;
    gnt_pct = 100; rv_pct = 100;
    apply_reset();
    exp_pc = 32'h4;
    for (int i = 0; i < 28; i++) begin
      dec_ready_i = (i == 16) || (i >= 18);
      @(negedge clk);
      if (i >= 9 && i <= 16) begin
        checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL full_req cycle %0d got %b exp 0", i, imem_req_o); end
      end
      if (i == 16) begin
        checks++; if (dec_valid_o !== 1'b1 || dec_pc_o !== 32'h0) begin
          errors++; $display("FAIL full_head got valid=%b pc=%h exp 1/00000000", dec_valid_o, dec_pc_o);
        end
      end
      if (i == 17) begin
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h10) begin
          errors++; $display("FAIL full_refetch got req=%b addr=%h exp 1/00000010", imem_req_o, imem_addr_o);
        end
      end
      if (i >= 18 && dec_valid_o) begin
        checks++; if (dec_pc_o !== exp_pc) begin errors++; $display("FAIL full_drain got %h exp %h", dec_pc_o, exp_pc); end
        exp_pc = exp_pc + 32'd4;
      end
      cyc();
    end
    checks++; if (exp_pc < 32'h14) begin errors++; $display("FAIL full_drain_count got next=%h exp >=00000014", exp_pc); end
    dec_ready_i = 0;
  endtask

  task automatic test_redirect_resp();
    gnt_pct = 100; rv_pct = 0;
    apply_reset();
    dec_ready_i = 1;
    for (int i = 0; i < 10; i++) begin
      redirect_i = (i == 2);
      redirect_pc_i = 32'h0000_1003;
      if (i == 4) rv_pct = 100;
      @(negedge clk);
      if (i >= 2 && i <= 7) begin
        checks++; if (dec_valid_o !== 1'b0) begin errors++; $display("FAIL rr_empty cycle %0d got %b exp 0", i, dec_valid_o); end
      end
      if (i >= 3 && i <= 5) begin
        checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL rr_drop_req cycle %0d got %b exp 0", i, imem_req_o); end
      end
      if (i == 6) begin
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h1000) begin
          errors++; $display("FAIL rr_newreq got req=%b addr=%h exp 1/00001000", imem_req_o, imem_addr_o);
        end
      end
      if (i == 8) begin
        checks++; if (dec_valid_o !== 1'b1 || dec_pc_o !== 32'h1000 || dec_instr_o !== mem_word(32'h1000)) begin
          errors++; $display("FAIL rr_first got valid=%b pc=%h instr=%h exp 1/00001000/%h", dec_valid_o, dec_pc_o, dec_instr_o, mem_word(32'h1000));
        end
      end
      cyc();
    end
    redirect_i = 0;
  endtask

  task automatic test_redirect_rvalid();
    gnt_pct = 100; rv_pct = 100;
    apply_reset();
    dec_ready_i = 1;
    for (int i = 0; i < 7; i++) begin
      redirect_i = (i == 2);
      redirect_pc_i = 32'h0000_2000;
      @(negedge clk);
      if (i >= 2 && i <= 4) begin
        checks++; if (dec_valid_o !== 1'b0) begin errors++; $display("FAIL rv_nopush cycle %0d got %b exp 0", i, dec_valid_o); end
      end
      if (i == 3) begin
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h2000) begin
          errors++; $display("FAIL rv_newreq got req=%b addr=%h exp 1/00002000", imem_req_o, imem_addr_o);
        end
      end
      if (i == 5) begin
        checks++; if (dec_valid_o !== 1'b1 || dec_pc_o !== 32'h2000) begin
          errors++; $display("FAIL rv_first got valid=%b pc=%h exp 1/00002000", dec_valid_o, dec_pc_o);
        end
      end
      cyc();
    end
    redirect_i = 0;
  endtask

  task automatic test_wrap();
    gnt_pct = 0; rv_pct = 100;
    apply_reset();
    dec_ready_i = 1;
    for (int i = 0; i < 6; i++) begin
      redirect_i = (i == 1);
      redirect_pc_i = 32'hFFFF_FFFE;
      if (i == 1) gnt_pct = 100;
      @(negedge clk);
      if (i == 2) begin
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hFFFF_FFFC) begin
          errors++; $display("FAIL wrap_req got req=%b addr=%h exp 1/fffffffc", imem_req_o, imem_addr_o);
        end
      end
      if (i == 3) begin
        checks++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL wrap_addr got %h exp 00000000", imem_addr_o); end
      end
      if (i == 4) begin
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
          errors++; $display("FAIL wrap_next_req got req=%b addr=%h exp 1/00000000", imem_req_o, imem_addr_o);
        end
        checks++; if (dec_valid_o !== 1'b1 || dec_pc_o !== 32'hFFFF_FFFC) begin
          errors++; $display("FAIL wrap_entry got valid=%b pc=%h exp 1/fffffffc", dec_valid_o, dec_pc_o);
        end
      end
      cyc();
    end
    redirect_i = 0;
  endtask

  task automatic test_async_reset();
    gnt_pct = 100; rv_pct = 100;
    apply_reset();
    dec_ready_i = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cyc();
    end
    @(negedge clk);
    checks++; if (dec_valid_o !== 1'b1) begin errors++; $display("FAIL ar_pre_valid got %b exp 1", dec_valid_o); end
    #1 rst = 0;
    #1;
    checks++; if (imem_req_o !== 1'b0 || dec_valid_o !== 1'b0 || dec_pc_o !== 32'h0) begin
      errors++; $display("FAIL ar_immediate got req=%b valid=%b pc=%h exp 0/0/0", imem_req_o, dec_valid_o, dec_pc_o);
    end
    cyc();
    rst = 1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      if (j == 1) begin
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== RESET_PC) begin
          errors++; $display("FAIL ar_restart got req=%b addr=%h exp 1/%h", imem_req_o, imem_addr_o, RESET_PC);
        end
      end
      if (j == 3) begin
        checks++; if (dec_valid_o !== 1'b1 || dec_pc_o !== RESET_PC) begin
          errors++; $display("FAIL ar_first got valid=%b pc=%h exp 1/%h", dec_valid_o, dec_pc_o, RESET_PC);
        end
      end
      cyc();
    end
  endtask

  task automatic test_random();
    bit exp_v;
    gnt_pct = 70; rv_pct = 60;
    apply_reset();
    m_pops = 0;
    for (int i = 0; i < 4000; i++) begin
      dec_ready_i   = (int'($urandom_range(99)) < 60);
      redirect_i    = (int'($urandom_range(99)) < 4);
      redirect_pc_i = $urandom();
      if (i % 500 == 0) begin
        gnt_pct = int'($urandom_range(100, 30));
        rv_pct  = int'($urandom_range(100, 30));
      end
      @(negedge clk);
      exp_v = (mq.size() != 0) && !redirect_i;
      checks++; if (dec_valid_o !== exp_v) begin
        errors++; $display("FAIL rnd_valid cycle %0d got %b exp %b", i, dec_valid_o, exp_v);
      end
      if (exp_v) begin
        checks++; if (dec_pc_o !== mq[0].pc || dec_instr_o !== mq[0].instr) begin
          errors++; $display("FAIL rnd_head cycle %0d got %h/%h exp %h/%h", i, dec_pc_o, dec_instr_o, mq[0].pc, mq[0].instr);
        end
      end
      if (imem_req_o) begin
        checks++; if (imem_addr_o !== m_pc) begin
          errors++; $display("FAIL rnd_addr cycle %0d got %h exp %h", i, imem_addr_o, m_pc);
        end
        checks++; if (m_outst || mq.size() >= DEPTH) begin
          errors++; $display("FAIL rnd_req_legal cycle %0d got outstanding=%0b count=%0d exp 0 and <%0d", i, m_outst, mq.size(), DEPTH);
        end
      end
      cyc();
    end
    redirect_i = 0;
    checks++; if (m_pops < 200) begin errors++; $display("FAIL rnd_progress got %0d pops exp >=200", m_pops); end
  endtask

  initial begin
    rst = 0; redirect_i = 0; redirect_pc_i = '0; dec_ready_i = 0;
    test_reset();
    test_zero_wait();
    test_full();
    test_redirect_resp();
    test_redirect_rvalid();
    test_wrap();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
